// File: rtl/serial_adder.sv
// Bit-serial adder: one FA cell, registered carry, WIDTH clocks per sum.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output OVF.

module fa (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic Q,
  output logic Co
);
  assign Q  = A ^ B ^ Ci;
  assign Co = (A & B) | (Ci & (A ^ B));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic             CO
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sa, sb, sr;
  logic               cr;
  logic [CNT_W-1:0]   cnt;
  logic               fa_q, fa_co;
  logic               load, last;

  fa u_fa (
    .A  (sa[0]),
    .B  (sb[0]),
    .Ci (cr),
    .Q  (fa_q),
    .Co (fa_co)
  );

  assign last = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = FIN;
      end
      FIN: begin
        // Accepting here gives the WIDTH+1 cycle back-to-back throughput.
        if (START) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control: state and registered status flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt == RUN);
      DONE  <= (state_nxt == FIN);
    end
  end

  // Datapath: operand shifters, carry, partial sum and result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      cr  <= 1'b0;
      cnt <= '0;
      Q   <= '0;
      CO  <= 1'b0;
    end else if (load) begin
      sa  <= A;
      sb  <= B;
      cr  <= CI;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= {1'b0, sa[WIDTH-1:1]};
      sb  <= {1'b0, sb[WIDTH-1:1]};
      cr  <= fa_co;
      sr  <= {fa_q, sr[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
      if (last) begin
        Q  <= {fa_q, sr[WIDTH-1:1]};
        CO <= fa_co;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the last bit cr is the carry into the MSB.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       OVF <= 1'b0;
    else if (last) OVF <= cr ^ fa_co;
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus corner sequences.

module tb_serial_adder;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CI = 1'b0;
  logic         BUSY, DONE, CO;
  logic [W-1:0] Q;
  logic         ovf;

  int n_vec = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .CI    (CI),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Q     (Q),
    .CO    (CO)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .OVF   (ovf)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] q;
    logic         co;
    logic         ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_ovf(input string nm, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
    check(nm, {31'd0, ovf}, {31'd0, exp});
`endif
  endtask

  // One full addition with START for a single cycle; inputs scrambled after accept.
  task automatic run_add(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic [W-1:0] eq, input logic eco,
                         input logic eovf);
    @(negedge CLK);
    START = 1'b1; A = a; B = b; CI = ci;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0; A = 8'($urandom); B = 8'($urandom); CI = 1'($urandom);
    check({nm, " busy e0"}, {31'd0, BUSY}, 32'd1);
    check({nm, " done e0"}, {31'd0, DONE}, 32'd0);
    for (int k = 1; k < W; k++) begin
      @(negedge CLK);
      check($sformatf("%s busy e%0d", nm, k), {31'd0, BUSY}, 32'd1);
      check($sformatf("%s done e%0d", nm, k), {31'd0, DONE}, 32'd0);
    end
    @(negedge CLK);
    check({nm, " done"}, {31'd0, DONE}, 32'd1);
    check({nm, " busy fin"}, {31'd0, BUSY}, 32'd0);
    check({nm, " q"}, {24'd0, Q}, {24'd0, eq});
    check({nm, " co"}, {31'd0, CO}, {31'd0, eco});
    check_ovf({nm, " ovf"}, eovf);
    @(negedge CLK);
    check({nm, " done clr"}, {31'd0, DONE}, 32'd0);
    check({nm, " idle busy"}, {31'd0, BUSY}, 32'd0);
    check({nm, " q held"}, {24'd0, Q}, {24'd0, eq});
  endtask

  initial begin
    int dones;
    logic [W-1:0] q_at_done;

    vecs[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};

    // Reset state
    @(negedge CLK);
    check("rst busy", {31'd0, BUSY}, 32'd0);
    check("rst done", {31'd0, DONE}, 32'd0);
    check("rst q", {24'd0, Q}, 32'd0);
    check("rst co", {31'd0, CO}, 32'd0);
    check_ovf("rst ovf", 1'b0);
    RST = 1'b0;

    foreach (vecs[i])
      run_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci,
              vecs[i].q, vecs[i].co, vecs[i].ovf);

    // START during RUN with new operands must be ignored
    @(negedge CLK);
    START = 1'b1; A = 8'h3C; B = 8'h42; CI = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    START = 1'b1; A = 8'hFF; B = 8'hFF; CI = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    dones = 0;
    q_at_done = '0;
    repeat (12) begin
      @(negedge CLK);
      if (DONE) begin
        dones++;
        q_at_done = Q;
      end
    end
    check("ign done count", dones, 32'd1);
    check("ign q", {24'd0, q_at_done}, 32'h7E);
    check("ign co", {31'd0, CO}, 32'd0);
    check("ign idle", {31'd0, BUSY}, 32'd0);

    // Asynchronous reset in the middle of a run
    @(negedge CLK);
    START = 1'b1; A = 8'hFF; B = 8'h01; CI = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("mid rst q", {24'd0, Q}, 32'd0);
    check("mid rst co", {31'd0, CO}, 32'd0);
    check("mid rst busy", {31'd0, BUSY}, 32'd0);
    check("mid rst done", {31'd0, DONE}, 32'd0);
    check_ovf("mid rst ovf", 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("mid rst no done", dones, 32'd0);
    check("mid rst q stays", {24'd0, Q}, 32'd0);
    run_add("post rst", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0);

    // START held high: one result every W+1 cycles
    @(negedge CLK);
    START = 1'b1; A = 8'h10; B = 8'h20; CI = 1'b0;
    for (int e = 0; e < 3 * (W + 1); e++) begin
      @(negedge CLK);
      if (e == 3 * (W + 1) - 1) START = 1'b0;
      check($sformatf("b2b done e%0d", e), {31'd0, DONE}, {31'd0, (e % (W + 1)) == W});
      check($sformatf("b2b busy e%0d", e), {31'd0, BUSY}, {31'd0, (e % (W + 1)) != W});
      if ((e % (W + 1)) == W)
        check($sformatf("b2b q e%0d", e), {24'd0, Q}, 32'h30);
    end
    @(negedge CLK);
    check("b2b end busy", {31'd0, BUSY}, 32'd0);
    check("b2b end done", {31'd0, DONE}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
